instr_fetch: RTL



---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, req/ack instruction fetch into an instruction register, and next-PC selection.
// Optional retired-instruction counter (retired_cnt port) is present only when INSTR_CNT_EN is defined.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  sa,
   output logic [15:0] imm16,
   output logic [25:0] target26,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        PCwrt,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   input  logic        sign,
   input  logic [31:0] ext_imm,
   output logic        halted
`ifdef INSTR_CNT_EN
   ,
   output logic [31:0] retired_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   state_t      state_r;
   logic        taken_s;
   logic [31:0] next_pc_s;

   assign imem_addr = pc;
   assign pc_plus4  = pc + 32'd4;
   assign op        = instr[31:26];
   assign rs        = instr[25:21];
   assign rt        = instr[20:16];
   assign rd        = instr[15:11];
   assign sa        = instr[10:6];
   assign funct     = instr[5:0];
   assign imm16     = instr[15:0];
   assign target26  = instr[25:0];

   // Branch condition from the opcode held in the instruction register, then next-PC priority mux.
   always_comb begin
      taken_s   = 1'b0;
      next_pc_s = pc_plus4;
      case (op)
         6'b000100: taken_s = zero;
         6'b000101: taken_s = ~zero;
         6'b000001: taken_s = sign;
         default:   taken_s = 1'b0;
      endcase
      if (jump) begin
         next_pc_s = {pc_plus4[31:28], target26, 2'b00};
      end else if (branch && taken_s) begin
         next_pc_s = pc_plus4 + (ext_imm << 2'd2);
      end else begin
         next_pc_s = pc_plus4;
      end
   end

   // Fetch FSM; req/valid/halted are registered alongside the state so they never see inputs combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         pc          <= PC_INIT;
         instr       <= 32'd0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r  <= FETCH;
               imem_req <= 1'b1;
            end
            FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state_r     <= EXEC;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end else begin
                  state_r <= FETCH;
               end
            end
            EXEC: begin
               instr_valid <= 1'b0;
               if (!PCwrt) begin
                  state_r <= HALT;
                  halted  <= 1'b1;
               end else begin
                  pc       <= next_pc_s;
                  state_r  <= FETCH;
                  imem_req <= 1'b1;
               end
            end
            HALT: begin
               state_r <= HALT;
            end
            default: begin
               state_r     <= IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

`ifdef INSTR_CNT_EN
   // Retired count; HALT never passes through EXEC again, so the count holds there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 32'd0;
      end else if (state_r == EXEC && PCwrt) begin
         retired_cnt <= retired_cnt + 32'd1;
      end else begin
         retired_cnt <= retired_cnt;
      end
   end
`endif

endmodule
